eco32f_icache_refill: RTL
=========================

Name: eco32f_icache_refill

Overview:
- Parametrised instruction-cache line refill engine for the eco32f fetch stage. It replaces the fixed 8-word refill logic embedded in fetch.
- Sits between the fetch unit (miss request, early-restart forwarding) and the instruction wishbone master port.
- Performs critical-word-first wrapping bursts of configurable line length.
- Adds bus-retry handling with a retry limit, and abort on pipeline flush.

Parameters:
- LINE_WORDS, 8: words per cache line; legal values 4, 8, 16. Selects the wrap size and the BTE code.
- RETRY_LIMIT, 3: number of rty_i responses tolerated per refill; one more raises bus_err.
- RETRY_GAP, 2: idle cycles (stb/cyc low) between an rty_i and the reissue; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_req  in  1  start refill; sampled only in IDLE
- miss_pa  in  32  physical address of the missing word
- abort  in  1  flush; kills any refill in progress
- busy  out  1  refill in progress (state != IDLE)
- done  out  1  one-cycle pulse; whole line written
- bus_err  out  1  one-cycle pulse; refill failed (err_i or retry limit)
- word_valid  out  LINE_WORDS  per-word valid bitmap of the line being filled
- fwd_valid  out  1  one-cycle pulse; critical word available
- fwd_data  out  32  critical word data
- cache_wr_en  out  1  cache data-array write strobe
- cache_wr_addr  out  32  word address written
- cache_wr_data  out  32  word data written
- iwbm_adr_o  out  32  wishbone address
- iwbm_cyc_o, iwbm_stb_o  out  1 each  wishbone cycle/strobe
- iwbm_cti_o  out  3  010 incrementing, 111 end-of-burst
- iwbm_bte_o  out  2  01 for 4 words, 10 for 8, 11 for 16
- iwbm_sel_o  out  4  constant 1111
- iwbm_we_o  out  1  constant 0
- iwbm_dat_o  out  32  constant 0
- iwbm_ack_i, iwbm_err_i, iwbm_rty_i  in  1 each  wishbone responses
- iwbm_dat_i  in  32  read data

Behaviour:
- Reset: all registered outputs go to 0, including iwbm_adr_o and word_valid; state IDLE; retry count 0.
- States: IDLE, BURST, RETRY_WAIT.
- IDLE, miss_req=1 and abort=0:
  - latch iwbm_adr_o = {miss_pa[31:2], 2'b00}; beat counter = LINE_WORDS-1; retry count = 0; word_valid = 0.
  - next cycle: cyc=stb=1, busy=1, state BURST.
- miss_req is ignored outside IDLE.
- BURST: cti = 111 when counter == 0, else 010.
- BURST, ack_i (no err_i, no abort) — effects in the next cycle:
  - cache_wr_en=1, cache_wr_addr = current iwbm_adr_o, cache_wr_data = dat_i.
  - word_valid[adr word offset] set.
  - On the first beat only: fwd_valid=1, fwd_data = dat_i.
  - The in-line offset adr[log2(LINE_WORDS)+1:2] increments mod LINE_WORDS; upper bits never change.
  - Counter decrements.
- BURST, ack_i with counter == 0: also drop cyc/stb, pulse done in the same cycle as the final write, go to IDLE.
- Latency:
  - first ack to fwd_valid: 1 cycle.
  - miss_req to cyc: 1 cycle.
- err_i (wins over a simultaneous ack_i):
  - no write for that beat;
  - drop cyc/stb; word_valid cleared; bus_err pulse; go to IDLE.
- rty_i (no err_i):
  - no write;
  - drop cyc/stb; retry count +1.
  - If the new count > RETRY_LIMIT: same handling as err_i.
  - Otherwise go to RETRY_WAIT for RETRY_GAP cycles, then reassert cyc/stb at the current address with the remaining counter. Already-written words stay valid.
- abort has the highest priority after rst:
  - in any non-IDLE state, next cycle cyc=stb=0, word_valid=0, state IDLE;
  - an ack arriving in the abort cycle is discarded (no write, no fwd_valid);
  - no done or bus_err pulse.
- abort together with miss_req in IDLE: the request is dropped.
- rst mid-burst: immediate return to the reset values; the bus cycle ends the next cycle.
- Invariant: done, bus_err and fwd_valid are never asserted while state == IDLE except the done/bus_err pulse coinciding with the IDLE transition.

Decomposition:
- Shared header eco32f.vh:
  - wishbone CTI codes (ECO32F_CTI_INCR, ECO32F_CTI_EOB);
  - BTE codes (ECO32F_BTE_WRAP4/8/16);
  - refill state encodings.
- Offset width is a localparam, log2 of LINE_WORDS.
- No sub-module. The fetch unit instantiates this block alongside eco32f_cache.

Test Plan:
- LINE_WORDS=8, miss_pa=0x1000_0014, ack every cycle:
  - addresses 0x14, 0x18, 0x1C, 0x00 … 0x10;
  - cti 111 only on the 0x10 beat; bte=10;
  - fwd_valid once with word 0x14 data;
  - done 1 cycle after the last ack; word_valid=0xFF.
- LINE_WORDS=4, miss_pa=0x0000_000C:
  - wrap 0xC, 0x0, 0x4, 0x8; bte=01; done after 4 writes.
- rty_i on beat 3, RETRY_GAP=2:
  - cyc low exactly 2 cycles, reissue at the same address;
  - word_valid keeps the first 2 bits; done still reached with 8 writes total.
- RETRY_LIMIT=3, rty_i on every stb:
  - 4th rty produces bus_err pulse;
  - word_valid=0, busy=0, no cache_wr_en ever.
- Error and abort cases:
  - err_i with ack_i on beat 5 → no write for that beat, bus_err pulse, IDLE.
  - abort on the cycle of beat 2's ack → no write, cyc low next cycle, no done.
  - A new miss_req afterwards starts a clean burst.
- Reset cases:
  - rst asserted mid-burst → all outputs 0 next cycle.
  - miss_req asserted together with abort in IDLE → no bus activity.

Source files
------------

// File: rtl/eco32f_icache_refill_pkg.sv
// Shared codes for the eco32f instruction-cache refill engine:
// wishbone burst tags and refill state encodings.
package eco32f_icache_refill_pkg;

    localparam logic [2:0] ECO32F_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] ECO32F_CTI_INCR    = 3'b010;
    localparam logic [2:0] ECO32F_CTI_EOB     = 3'b111;

    localparam logic [1:0] ECO32F_BTE_WRAP4  = 2'b01;
    localparam logic [1:0] ECO32F_BTE_WRAP8  = 2'b10;
    localparam logic [1:0] ECO32F_BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        REFILL_IDLE       = 2'd0,
        REFILL_BURST      = 2'd1,
        REFILL_RETRY_WAIT = 2'd2
    } refill_state_e;

    function automatic logic [1:0] bte_code(input int words);
        case (words)
            4:       return ECO32F_BTE_WRAP4;
            16:      return ECO32F_BTE_WRAP16;
            default: return ECO32F_BTE_WRAP8;
        endcase
    endfunction

endpackage

// File: rtl/eco32f_icache_refill.sv
// Critical-word-first wrapping line refill for the eco32f fetch stage,
// with bus-retry backoff, retry limit and flush abort.
module eco32f_icache_refill
    import eco32f_icache_refill_pkg::*;
#(
    parameter int LINE_WORDS  = 8,
    parameter int RETRY_LIMIT = 3,
    parameter int RETRY_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [31:0]           miss_pa,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  bus_err,
    output logic [LINE_WORDS-1:0] word_valid,
    output logic                  fwd_valid,
    output logic [31:0]           fwd_data,
    output logic                  cache_wr_en,
    output logic [31:0]           cache_wr_addr,
    output logic [31:0]           cache_wr_data,
    output logic [31:0]           iwbm_adr_o,
    output logic                  iwbm_cyc_o,
    output logic                  iwbm_stb_o,
    output logic [2:0]            iwbm_cti_o,
    output logic [1:0]            iwbm_bte_o,
    output logic [3:0]            iwbm_sel_o,
    output logic                  iwbm_we_o,
    output logic [31:0]           iwbm_dat_o,
    input  logic                  iwbm_ack_i,
    input  logic                  iwbm_err_i,
    input  logic                  iwbm_rty_i,
    input  logic [31:0]           iwbm_dat_i
);

    localparam int OFFW = $clog2(LINE_WORDS);
    localparam int RCW  = $clog2(RETRY_LIMIT + 2);

    refill_state_e         state, state_d;
    logic [31:0]           adr, adr_d;
    logic [OFFW-1:0]       cnt, cnt_d;
    logic [RCW-1:0]        rcnt, rcnt_d, rcnt_inc;
    logic [3:0]            gap, gap_d;
    logic [LINE_WORDS-1:0] wv, wv_d;
    logic                  cyc, cyc_d;
    logic                  wr_en, wr_en_d;
    logic [31:0]           wr_addr, wr_addr_d, wr_data, wr_data_d;
    logic                  fwd_v, fwd_v_d;
    logic [31:0]           fwd_d, fwd_d_d;
    logic                  done_r, done_d, err_r, err_d;
    logic                  fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REFILL_IDLE;
            adr     <= '0;
            cnt     <= '0;
            rcnt    <= '0;
            gap     <= '0;
            wv      <= '0;
            cyc     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            fwd_v   <= 1'b0;
            fwd_d   <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_d;
            adr     <= adr_d;
            cnt     <= cnt_d;
            rcnt    <= rcnt_d;
            gap     <= gap_d;
            wv      <= wv_d;
            cyc     <= cyc_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            fwd_v   <= fwd_v_d;
            fwd_d   <= fwd_d_d;
            done_r  <= done_d;
            err_r   <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        adr_d     = adr;
        cnt_d     = cnt;
        rcnt_d    = rcnt;
        gap_d     = gap;
        wv_d      = wv;
        cyc_d     = cyc;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        fwd_v_d   = 1'b0;
        fwd_d_d   = fwd_d;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;
        rcnt_inc  = rcnt + RCW'(1);

        if (state != REFILL_IDLE && abort) begin
            state_d = REFILL_IDLE;
            cyc_d   = 1'b0;
            wv_d    = '0;
        end else begin
            case (state)
                REFILL_IDLE: begin
                    if (miss_req && !abort) begin
                        adr_d   = miss_pa & ~32'h3;
                        cnt_d   = OFFW'(LINE_WORDS - 1);
                        rcnt_d  = '0;
                        wv_d    = '0;
                        cyc_d   = 1'b1;
                        state_d = REFILL_BURST;
                    end
                end
                REFILL_BURST: begin
                    if (iwbm_err_i || (iwbm_rty_i && rcnt_inc > RCW'(RETRY_LIMIT))) begin
                        fail = 1'b1;
                    end else if (iwbm_rty_i) begin
                        rcnt_d  = rcnt_inc;
                        gap_d   = 4'(RETRY_GAP - 1);
                        cyc_d   = 1'b0;
                        state_d = REFILL_RETRY_WAIT;
                    end else if (iwbm_ack_i) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = adr;
                        wr_data_d = iwbm_dat_i;
                        wv_d[adr[OFFW+1:2]] = 1'b1;
                        // Nothing written yet means this beat is the critical word.
                        if (wv == '0) begin
                            fwd_v_d = 1'b1;
                            fwd_d_d = iwbm_dat_i;
                        end
                        adr_d[OFFW+1:2] = adr[OFFW+1:2] + OFFW'(1);
                        cnt_d = cnt - OFFW'(1);
                        if (cnt == '0) begin
                            cyc_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = REFILL_IDLE;
                        end
                    end
                end
                REFILL_RETRY_WAIT: begin
                    if (gap == '0) begin
                        cyc_d   = 1'b1;
                        state_d = REFILL_BURST;
                    end else begin
                        gap_d = gap - 4'd1;
                    end
                end
                default: state_d = REFILL_IDLE;
            endcase
        end

        if (fail) begin
            cyc_d   = 1'b0;
            wv_d    = '0;
            err_d   = 1'b1;
            state_d = REFILL_IDLE;
        end
    end

    assign busy          = (state != REFILL_IDLE);
    assign done          = done_r;
    assign bus_err       = err_r;
    assign word_valid    = wv;
    assign fwd_valid     = fwd_v;
    assign fwd_data      = fwd_d;
    assign cache_wr_en   = wr_en;
    assign cache_wr_addr = wr_addr;
    assign cache_wr_data = wr_data;
    assign iwbm_adr_o    = adr;
    assign iwbm_cyc_o    = cyc;
    assign iwbm_stb_o    = cyc;
    assign iwbm_cti_o    = !cyc ? ECO32F_CTI_CLASSIC :
                           (cnt == '0) ? ECO32F_CTI_EOB : ECO32F_CTI_INCR;
    assign iwbm_bte_o    = bte_code(LINE_WORDS);
    assign iwbm_sel_o    = 4'hF;
    assign iwbm_we_o     = 1'b0;
    assign iwbm_dat_o    = '0;

endmodule
